// File: rtl/mux_led_pkg.sv
// Shared constants for the LED multiplexer: FSM state codes, default parameters
// and a width helper used by the sub-blocks.
package mux_led_pkg;

    localparam logic [0:0] ST_MANUAL = 1'b0;
    localparam logic [0:0] ST_SCAN   = 1'b1;

    localparam int DEF_SEL_W       = 2;
    localparam int DEF_SYNC_STAGES = 2;
    localparam int DEF_DEB_CNT     = 16;
    localparam int DEF_SCAN_DIV    = 12000000;

    // Bits needed to hold values 0..v-1 (never less than 1).
    function automatic int clog2(input int v);
        int r;
        int x;
        r = 0;
        x = v - 1;
        while (x > 0) begin
            r++;
            x = x >> 1;
        end
        return (r < 1) ? 1 : r;
    endfunction

endpackage

// File: rtl/mux_led_scan_if.sv
// Board-facing signal bundle of the LED multiplexer; master drives the switches/data,
// slave is the multiplexer itself.
interface mux_led_scan_if #(
    parameter int SEL_W = 2
);
    localparam int N = 1 << SEL_W;

    logic [SEL_W-1:0] sel_in;
    logic [N-1:0]     data_in;
    logic             scan_en;
    logic             led_o;
    logic [SEL_W-1:0] sel_o;
    logic             sel_valid;

    modport master (
        output sel_in, data_in, scan_en,
        input  led_o, sel_o, sel_valid
    );

    modport slave (
        input  sel_in, data_in, scan_en,
        output led_o, sel_o, sel_valid
    );
endinterface

// File: rtl/mux_led_debounce.sv
// Synchroniser plus whole-vector debouncer: a new value is accepted only after it has
// been seen unchanged for DEB_CNT consecutive cycles. Reusable for push-buttons.
module mux_led_debounce
    import mux_led_pkg::*;
#(
    parameter int WIDTH       = 2,
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CNT     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] raw_i,
    output logic [WIDTH-1:0] db_o,
    output logic [WIDTH-1:0] db_next_o,
    output logic             valid_o
);
    localparam int CNT_W = clog2(DEB_CNT + 1);

    logic [WIDTH-1:0] sync_w;
    logic [WIDTH-1:0] cand_q, cand_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] db_q, db_d;
    logic             valid_q, valid_d;

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [WIDTH-1:0] stage_q;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_q <= '0;
                    else        stage_q <= raw_i;
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) stage_q <= '0;
                    else        stage_q <= g_sync[gi-1].stage_q;
                end
            end
        end
    endgenerate

    assign sync_w = g_sync[SYNC_STAGES-1].stage_q;

    // Any disagreement with the candidate restarts the stability window.
    always_comb begin
        cand_d  = cand_q;
        cnt_d   = cnt_q;
        db_d    = db_q;
        valid_d = valid_q;
        if (sync_w != cand_q) begin
            cand_d = sync_w;
            cnt_d  = '0;
        end else if (cnt_q < CNT_W'(DEB_CNT - 1)) begin
            cnt_d = cnt_q + 1'b1;
        end else begin
            db_d    = cand_q;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cand_q  <= '0;
            cnt_q   <= '0;
            db_q    <= '0;
            valid_q <= 1'b0;
        end else begin
            cand_q  <= cand_d;
            cnt_q   <= cnt_d;
            db_q    <= db_d;
            valid_q <= valid_d;
        end
    end

    assign db_o      = db_q;
    assign db_next_o = db_d;
    assign valid_o   = valid_q;
endmodule

// File: rtl/mux_led_scan.sv
// N:1 LED multiplexer with debounced switch select and an automatic SCAN mode that
// steps through every channel once per SCAN_DIV clocks.
module mux_led_scan
    import mux_led_pkg::*;
#(
    parameter int SEL_W       = DEF_SEL_W,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES,
    parameter int DEB_CNT     = DEF_DEB_CNT,
    parameter int SCAN_DIV    = DEF_SCAN_DIV
) (
    input  logic           clk,
    input  logic           rst_n,
    mux_led_scan_if.slave  bus
);
    localparam int N     = 1 << SEL_W;
    localparam int DIV_W = clog2(SCAN_DIV + 1);

    logic [SEL_W-1:0] sel_db_w, sel_db_next_w;
    logic             sel_valid_w;
    logic [N-1:0]     data_sync_w;
    logic             scan_sync_w;

    logic [0:0]       state_q, state_d;
    logic [DIV_W-1:0] div_q, div_d;
    logic [SEL_W-1:0] sel_q, sel_d;
    logic             led_q;

    mux_led_debounce #(
        .WIDTH       (SEL_W),
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CNT     (DEB_CNT)
    ) u_sel_db (
        .clk       (clk),
        .rst_n     (rst_n),
        .raw_i     (bus.sel_in),
        .db_o      (sel_db_w),
        .db_next_o (sel_db_next_w),
        .valid_o   (sel_valid_w)
    );

    genvar gi;
    generate
        for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
            logic [N-1:0] data_q;
            logic         scan_q;
            if (gi == 0) begin : g_first
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        data_q <= '0;
                        scan_q <= 1'b0;
                    end else begin
                        data_q <= bus.data_in;
                        scan_q <= bus.scan_en;
                    end
                end
            end else begin : g_rest
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        data_q <= '0;
                        scan_q <= 1'b0;
                    end else begin
                        data_q <= g_sync[gi-1].data_q;
                        scan_q <= g_sync[gi-1].scan_q;
                    end
                end
            end
        end
    endgenerate

    assign data_sync_w = g_sync[SYNC_STAGES-1].data_q;
    assign scan_sync_w = g_sync[SYNC_STAGES-1].scan_q;

    // Manual tracking uses the debouncer's next value so a commit landing on the
    // SCAN->MANUAL edge is picked up, and a falling scan_en always beats a step.
    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        sel_d   = sel_q;
        if (!scan_sync_w) begin
            state_d = ST_MANUAL;
            div_d   = '0;
            sel_d   = sel_db_next_w;
        end else if (state_q == ST_MANUAL) begin
            state_d = ST_SCAN;
            div_d   = '0;
        end else if (div_q == DIV_W'(SCAN_DIV - 1)) begin
            div_d = '0;
            sel_d = sel_q + 1'b1;
        end else begin
            div_d = div_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_MANUAL;
            div_q   <= '0;
            sel_q   <= '0;
            led_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            sel_q   <= sel_d;
            led_q   <= data_sync_w[sel_q];
        end
    end

    assign bus.led_o     = led_q;
    assign bus.sel_o     = sel_q;
    assign bus.sel_valid = sel_valid_w;
endmodule

// File: tb/tb_mux_led_scan.sv
// Randomised bench for mux_led_scan against a latency/arithmetic reference model.
module tb_mux_led_scan;
    localparam int SEL_W       = 2;
    localparam int N           = 1 << SEL_W;
    localparam int SYNC_STAGES = 2;
    localparam int DEB_CNT     = 4;
    localparam int SCAN_DIV    = 5;
    localparam int DEB_LO      = SYNC_STAGES + DEB_CNT;
    localparam int DEB_HI      = SYNC_STAGES + DEB_CNT + 1;
    localparam int DATA_LAT    = SYNC_STAGES + 1;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    mux_led_scan_if #(.SEL_W(SEL_W)) bus ();

    mux_led_scan #(
        .SEL_W       (SEL_W),
        .SYNC_STAGES (SYNC_STAGES),
        .DEB_CNT     (DEB_CNT),
        .SCAN_DIV    (SCAN_DIV)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input int unsigned obs, input int unsigned exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic int unsigned ref_led(input int unsigned d, input int unsigned s);
        return (d >> s) & 1;
    endfunction

    // Select k edges after scan_en rises: entry is seen after SYNC_STAGES+1 edges,
    // then one step per SCAN_DIV edges, modulo N.
    function automatic int unsigned ref_scan_sel(input int unsigned start, input int k);
        int steps;
        steps = (k < DATA_LAT) ? 0 : (k - DATA_LAT) / SCAN_DIV;
        return (start + steps) % N;
    endfunction

    // Counts edges until sel_o reaches target and checks it landed inside [lo,hi].
    task automatic wait_sel(input string tag, input int unsigned target, input int lo, input int hi);
        int n;
        bit hit;
        n = 0;
        hit = 1'b0;
        while (!hit && n < hi + 3) begin
            tick();
            n++;
            if (bus.sel_o == target) hit = 1'b1;
        end
        check_val(tag, (hit && n >= lo && n <= hi) ? 1 : 0, 1);
    endtask

    initial begin
        int unsigned d_prev, d_new, ch, v, exp_sel, prev_sel;
        int unsigned pats [4];
        n_checks = 0;
        n_errors = 0;

        // Reset held with random inputs
        rst_n = 1'b0;
        bus.scan_en = 1'b0;
        for (int i = 0; i < 6; i++) begin
            bus.sel_in  = SEL_W'($urandom);
            bus.data_in = N'($urandom);
            tick();
            check_val("rst_led", bus.led_o, 0);
            check_val("rst_sel", bus.sel_o, 0);
            check_val("rst_valid", bus.sel_valid, 0);
        end

        // First debounced commit
        bus.sel_in  = 2'd2;
        bus.data_in = '0;
        rst_n = 1'b1;
        wait_sel("first_commit", 2, DEB_LO, DEB_HI);
        check_val("valid_after_commit", bus.sel_valid, 1);
        tick();
        tick();

        // Manual mux across all channels
        d_prev = 0;
        for (int c = 0; c < N; c++) begin
            ch = (2 + c) % N;
            if (c != 0) begin
                bus.sel_in = SEL_W'(ch);
                wait_sel($sformatf("manual_sel%0d", ch), ch, DEB_LO, DEB_HI);
                tick();
            end
            pats[0] = 1 << ch;
            pats[1] = 0;
            pats[2] = $urandom & (N - 1);
            pats[3] = ~(1 << ch) & (N - 1);
            for (int p = 0; p < 4; p++) begin
                d_new = pats[p];
                bus.data_in = N'(d_new);
                tick();
                tick();
                check_val($sformatf("led_hold_c%0d_p%0d", ch, p), bus.led_o, ref_led(d_prev, ch));
                tick();
                check_val($sformatf("led_new_c%0d_p%0d", ch, p), bus.led_o, ref_led(d_new, ch));
                d_prev = d_new;
            end
        end

        // Bounce: 0/3 toggling every 2 cycles must never commit
        bus.sel_in = 2'd0;
        wait_sel("bounce_base", 0, DEB_LO, DEB_HI);
        for (int i = 0; i < 10; i++) begin
            bus.sel_in = (i % 2 == 0) ? 2'd3 : 2'd0;
            tick();
            check_val("bounce_hold", bus.sel_o, 0);
            tick();
            check_val("bounce_hold", bus.sel_o, 0);
        end
        bus.sel_in = 2'd3;
        wait_sel("bounce_settle", 3, DEB_LO, DEB_HI);

        // Scan from channel 2 with wrap, switches moved to 1 meanwhile
        bus.data_in = 4'b1010;
        bus.sel_in  = 2'd2;
        wait_sel("scan_start_sel", 2, DEB_LO, DEB_HI);
        for (int i = 0; i < DATA_LAT; i++) tick();
        bus.scan_en = 1'b1;
        for (int k = 1; k <= DATA_LAT + 4 * SCAN_DIV; k++) begin
            tick();
            check_val($sformatf("scan_sel_k%0d", k), bus.sel_o, ref_scan_sel(2, k));
            check_val($sformatf("scan_led_k%0d", k), bus.led_o, ref_led(4'b1010, ref_scan_sel(2, k - 1)));
            if (k == 2) bus.sel_in = 2'd1;
        end

        // Exit scan right after a step: sel_o follows switches on the 3rd edge
        bus.scan_en = 1'b0;
        prev_sel = 2;
        for (int j = 1; j <= 15; j++) begin
            tick();
            exp_sel = (j < DATA_LAT) ? 2 : 1;
            check_val($sformatf("exit_sel_j%0d", j), bus.sel_o, exp_sel);
            check_val($sformatf("exit_led_j%0d", j), bus.led_o, ref_led(4'b1010, prev_sel));
            prev_sel = exp_sel;
        end

        // Async reset mid-scan
        bus.data_in = 4'hF;
        bus.scan_en = 1'b1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_val($sformatf("rscan_sel_k%0d", k), bus.sel_o, ref_scan_sel(1, k));
            if (k >= DATA_LAT) check_val("rscan_led", bus.led_o, 1);
        end
        #2;
        rst_n = 1'b0;
        #1;
        check_val("async_led", bus.led_o, 0);
        check_val("async_sel", bus.sel_o, 0);
        check_val("async_valid", bus.sel_valid, 0);
        tick();
        bus.scan_en = 1'b0;
        bus.sel_in  = 2'd3;
        rst_n = 1'b1;
        tick();
        check_val("post_rst_valid", bus.sel_valid, 0);
        check_val("post_rst_sel", bus.sel_o, 0);
        wait_sel("post_rst_commit", 3, DEB_LO - 1, DEB_HI - 1);
        check_val("post_rst_valid_set", bus.sel_valid, 1);
        for (int i = 0; i < 3 * SCAN_DIV; i++) begin
            tick();
            v = bus.sel_o;
            check_val("post_rst_manual", v, 3);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
